// File: rtl/dp_pkg.sv
// dp_pkg: shared FSM state type and default parameters for the dot-product engine.
package dp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } dp_state_e;

    localparam int DEF_LANES  = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_LEN_W  = 12;
    localparam int DEF_CYC_W  = 16;

endpackage

// File: rtl/dp_adder_tree.sv
// dp_adder_tree: combinational balanced sum of LANES unsigned operands.
module dp_adder_tree #(
    parameter int LANES = 4,
    parameter int IN_W  = 16
) (
    input  logic [LANES*IN_W-1:0]           operands,
    output logic [IN_W+$clog2(LANES)-1:0]   sum
);
    localparam int OUT_W = IN_W + $clog2(LANES);

    // Recursive halving gives a log2(LANES)-deep tree.
    if (LANES == 1) begin : g_leaf
        assign sum = operands;
    end else begin : g_split
        localparam int HALF = LANES / 2;
        logic [OUT_W-2:0] lo_sum, hi_sum;
        dp_adder_tree #(.LANES(HALF), .IN_W(IN_W)) u_lo (
            .operands(operands[HALF*IN_W-1:0]),
            .sum     (lo_sum)
        );
        dp_adder_tree #(.LANES(HALF), .IN_W(IN_W)) u_hi (
            .operands(operands[LANES*IN_W-1:HALF*IN_W]),
            .sum     (hi_sum)
        );
        assign sum = OUT_W'(lo_sum) + OUT_W'(hi_sum);
    end

endmodule

// File: rtl/dot_product_engine.sv
// dot_product_engine: streams LANES-wide operand beats through a 3-stage
// multiply / adder-tree / accumulate pipeline and reports the dot product.
module dot_product_engine
    import dp_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int CYC_W  = DEF_CYC_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LEN_W-1:0]        vec_len,
    input  logic                    in_valid,
    input  logic [LANES*DATA_W-1:0] a_data,
    input  logic [LANES*DATA_W-1:0] b_data,
    output logic                    in_ready,
    output logic                    busy,
    output logic                    done,
    output logic [ACC_W-1:0]        result,
    output logic                    result_valid,
    output logic                    overflow,
    output logic [CYC_W-1:0]        cycle_count
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);

    dp_state_e state, state_nx;
    logic [LEN_W-1:0] beats_left;
    logic [LANES*PROD_W-1:0] prod_q;
    logic [SUM_W-1:0] tree_sum, sum_q;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0] acc_nx;
    logic v1, l1, v2, l2;
    logic accept, xfer, last_xfer, last_add;

    assign accept    = start && state == IDLE;
    assign xfer      = in_valid && in_ready;
    assign last_xfer = xfer && beats_left == LEN_W'(1);
    assign last_add  = v2 && l2;
    assign acc_nx    = {1'b0, acc} + (ACC_W+1)'(sum_q);
    assign result    = acc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (vec_len == '0) ? DONE : RUN;
            RUN:     if (last_xfer) state_nx = DRAIN;
            DRAIN:   if (last_add) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = state == RUN && beats_left != '0;
        busy     = state == RUN || state == DRAIN;
        done     = state == DONE;
    end

    dp_adder_tree #(.LANES(LANES), .IN_W(PROD_W)) u_tree (
        .operands(prod_q),
        .sum     (tree_sum)
    );

    // Each stage carries a valid bit and a last-beat marker alongside its data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1     <= 1'b0;
            l1     <= 1'b0;
            v2     <= 1'b0;
            l2     <= 1'b0;
            prod_q <= '0;
            sum_q  <= '0;
        end else begin
            v1 <= xfer;
            l1 <= last_xfer;
            v2 <= v1;
            l2 <= l1;
            if (xfer)
                for (int i = 0; i < LANES; i++)
                    prod_q[i*PROD_W +: PROD_W] <= PROD_W'(a_data[i*DATA_W +: DATA_W])
                                                * PROD_W'(b_data[i*DATA_W +: DATA_W]);
            if (v1) sum_q <= tree_sum;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beats_left   <= '0;
            acc          <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
            cycle_count  <= '0;
        end else if (accept) begin
            beats_left   <= vec_len;
            acc          <= '0;
            overflow     <= 1'b0;
            result_valid <= vec_len == '0;
            cycle_count  <= '0;
        end else begin
            if (xfer) beats_left <= beats_left - LEN_W'(1);
            if (v2) begin
                acc      <= acc_nx[ACC_W-1:0];
                overflow <= overflow | acc_nx[ACC_W];
            end
            if (busy && cycle_count != '1) cycle_count <= cycle_count + CYC_W'(1);
            if (last_add) result_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dot_product_engine.sv
// tb_dot_product_engine: directed and randomized runs checked against a
// plain-arithmetic dot-product reference.
module tb_dot_product_engine;
    localparam int LANES = 4, DATA_W = 8, ACC_W = 24, LEN_W = 12, CYC_W = 16;
    localparam longint MODV = 64'd1 << ACC_W;

    logic clock = 1'b0;
    logic reset, start, in_valid;
    logic [LEN_W-1:0] vec_len;
    logic [LANES*DATA_W-1:0] a_data, b_data;
    logic in_ready, busy, done, result_valid, overflow;
    logic [ACC_W-1:0] result;
    logic [CYC_W-1:0] cycle_count;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dot_product_engine #(
        .LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .CYC_W(CYC_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .vec_len     (vec_len),
        .in_valid    (in_valid),
        .a_data      (a_data),
        .b_data      (b_data),
        .in_ready    (in_ready),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_valid(result_valid),
        .overflow    (overflow),
        .cycle_count (cycle_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] lane_val(input int mode, input bit is_b, input int i);
        case (mode)
            1:       return is_b ? DATA_W'(5 + i) : DATA_W'(1 + i);
            2:       return is_b ? DATA_W'(2) : DATA_W'(1);
            3:       return DATA_W'(255);
            default: return DATA_W'($urandom);
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_rv"}, result_valid, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_cyc"}, cycle_count, 0);
    endtask

    // gap < 0 means a random 0..2 bubble cycles before each beat after the first
    task automatic run_op(input string tag, input int len, input int gap, input int mode, input bit inject);
        longint total = 0;
        int run_cyc = 0;
        int wait_n = 1;
        bit seen = 0;
        @(negedge clock);
        start = 1;
        vec_len = LEN_W'(len);
        @(negedge clock);
        start = 0;
        check({tag, "_rv_cleared"}, result_valid, 0);
        check({tag, "_busy_run"}, busy, 1);
        for (int b = 0; b < len; b++) begin
            int g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            if (b > 0)
                repeat (g) begin
                    in_valid = 0;
                    @(negedge clock);
                    run_cyc++;
                end
            for (int i = 0; i < LANES; i++) begin
                logic [DATA_W-1:0] av, bv;
                av = lane_val(mode, 0, i);
                bv = lane_val(mode, 1, i);
                a_data[i*DATA_W +: DATA_W] = av;
                b_data[i*DATA_W +: DATA_W] = bv;
                total += longint'(av) * longint'(bv);
            end
            in_valid = 1;
            if (inject && b == 1) begin
                start = 1;
                vec_len = LEN_W'(len + 7);
            end
            if (b == 0) check({tag, "_in_ready"}, in_ready, 1);
            @(negedge clock);
            run_cyc++;
            start = 0;
        end
        in_valid = 0;
        a_data = $urandom;
        b_data = $urandom;
        check({tag, "_ready_drain"}, in_ready, 0);
        while (!seen && wait_n <= 8) begin
            if (done) seen = 1;
            else begin
                @(negedge clock);
                wait_n++;
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_done_latency"}, wait_n, 3);
        check({tag, "_result"}, result, total % MODV);
        check({tag, "_rv"}, result_valid, 1);
        check({tag, "_ovf"}, overflow, total >= MODV);
        check({tag, "_cyc"}, cycle_count, run_cyc + 2);
        check({tag, "_busy_done"}, busy, 0);
        @(negedge clock);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_rv_hold"}, result_valid, 1);
        check({tag, "_result_hold"}, result, total % MODV);
    endtask

    initial begin
        reset = 1;
        start = 0;
        in_valid = 0;
        vec_len = '0;
        a_data = '0;
        b_data = '0;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset = 0;
        @(negedge clock);
        check_all_zero("idle");

        run_op("single", 1, 0, 1, 0);
        run_op("gapped", 3, 2, 2, 0);
        run_op("wrap", 256, 0, 3, 0);
        run_op("inject", 4, 0, 0, 1);
        for (int k = 0; k < 4; k++) run_op("rand", int'($urandom_range(1, 6)), -1, 0, 0);

        // Zero-length vector: DONE immediately, no beats accepted.
        @(negedge clock);
        start = 1;
        vec_len = '0;
        check("zero_ready_idle", in_ready, 0);
        @(negedge clock);
        start = 0;
        check("zero_done", done, 1);
        check("zero_result", result, 0);
        check("zero_rv", result_valid, 1);
        check("zero_cyc", cycle_count, 0);
        check("zero_ready", in_ready, 0);
        check("zero_busy", busy, 0);
        @(negedge clock);
        check("zero_done_pulse", done, 0);
        check("zero_ready_after", in_ready, 0);

        // Abort mid-RUN via asynchronous reset.
        start = 1;
        vec_len = LEN_W'(5);
        @(negedge clock);
        start = 0;
        in_valid = 1;
        a_data = $urandom;
        b_data = $urandom;
        repeat (4) @(negedge clock);
        in_valid = 0;
        #1 reset = 1;
        #1 check_all_zero("abort");
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("abort_no_done", done, 0);
        end
        reset = 0;
        @(negedge clock);
        check_all_zero("post_abort");
        run_op("after_abort", 1, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_product_engine.md
DOT_PRODUCT_ENGINE -- requirements
Module: dot_product_engine

Interface
REQ-001 Parameter LANES, default 4: products per beat; a power of two, at least 2.
REQ-002 Parameter DATA_W, default 8: unsigned operand width.
REQ-003 Parameter ACC_W, default 24: accumulator and result width, at least 2*DATA_W+log2(LANES).
REQ-004 Parameter LEN_W, default 12: vec_len width.
REQ-005 Parameter CYC_W, default 16: cycle_count width.
REQ-006 clock  in  1  single clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  request to begin a new dot product.
REQ-009 vec_len  in  LEN_W  number of LANES-wide beats; sampled when start is accepted.
REQ-010 in_valid  in  1  a_data and b_data hold a valid beat.
REQ-011 a_data  in  LANES*DATA_W  A operands; lane i is bits [i*DATA_W +: DATA_W].
REQ-012 b_data  in  LANES*DATA_W  B operands, same lane packing as a_data.
REQ-013 in_ready  out  1  engine accepts a beat this cycle.
REQ-014 busy  out  1  high in RUN and DRAIN states.
REQ-015 done  out  1  one-cycle pulse marking the result as final.
REQ-016 result  out  ACC_W  accumulated sum.
REQ-017 result_valid  out  1  result is final.
REQ-018 overflow  out  1  sticky flag: the accumulator wrapped.
REQ-019 cycle_count  out  CYC_W  number of busy cycles in the current or last operation.

Function
REQ-020 The engine SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-021 start SHALL be accepted only in IDLE; start in any other state SHALL be ignored.
REQ-022 Accepting start with vec_len>0 SHALL latch vec_len, clear the accumulator, overflow, cycle_count and result_valid, and enter RUN.
REQ-023 Accepting start with vec_len=0 SHALL clear the same state and enter DONE directly, giving result=0 with done high in the next cycle.
REQ-024 in_ready SHALL equal (state==RUN) with beats remaining >0; a beat transfers when in_valid&&in_ready is high at a clock edge.
REQ-025 The datapath SHALL have three stages: stage 1 registers LANES products of width 2*DATA_W; stage 2 registers the adder-tree sum of width 2*DATA_W+log2(LANES); stage 3 adds that sum into the ACC_W accumulator.
REQ-026 Each pipeline stage SHALL carry a valid bit; cycles where in_valid is low (bubbles) SHALL add nothing.
REQ-027 RUN SHALL move to DRAIN on the edge that transfers the last beat; DRAIN SHALL move to DONE when the stage 3 update of the last beat occurs.
REQ-028 done and result_valid SHALL rise 3 cycles after the cycle in which the last beat transfers.
REQ-029 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-030 result and result_valid SHALL hold their values until the next accepted start or reset.
REQ-031 Accumulation SHALL wrap modulo 2^ACC_W; any carry out of bit ACC_W-1 SHALL set overflow, which stays set until the next start.
REQ-032 cycle_count SHALL increment by 1 every cycle that busy is high and saturate at 2^CYC_W-1; for N gap-free beats it SHALL equal N+2.
REQ-033 result SHALL continuously reflect the accumulator register.

Reset
REQ-034 Asserting reset SHALL immediately put the FSM in IDLE, clear every pipeline valid bit and the accumulator, and drive in_ready, busy, done, result_valid, overflow, result and cycle_count to 0.
REQ-035 Reset asserted mid-RUN or mid-DRAIN SHALL abort the operation with no done pulse; the next start after reset deasserts SHALL behave exactly as from power-up.

Structure
REQ-036 Package dp_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-037 The adder tree SHALL be a sub-module, dp_adder_tree, parametrised by LANES and input width, combinational, instantiated once ahead of the stage 2 register.

Verification (LANES=4, DATA_W=8, ACC_W=24)
REQ-038 vec_len=1, a={1,2,3,4}, b={5,6,7,8}, in_valid always high -> result=70, done pulse 3 cycles after the beat transfers, cycle_count=3, overflow=0.
REQ-039 vec_len=3 with in_valid low for 2 cycles between each beat, beats all-ones x all-twos -> result=24, cycle_count=9.
REQ-040 vec_len=256, every lane 255x255 -> overflow=1, result=16253952.
REQ-041 vec_len=0 -> done in the cycle after start, result=0, cycle_count=0, in_ready never high.
REQ-042 reset pulsed mid-RUN -> all outputs 0 with no done pulse; a following vec_len=1 run gives the REQ-038 result.
REQ-043 start pulsed during RUN with a different vec_len -> ignored; the original operation completes unchanged.
